fifo_uart_tx: RTL

Downstream consumer of the 16-bit word FIFO. When the FIFO holds data, the block pops one word and serialises it onto a UART TX line as two 8N1 frames, low byte first. It is the drain stage between the FIFO and the board's serial pin.

---
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a 16-bit word FIFO onto a UART TX line. Each popped word is sent as
// two 8N1 frames, low byte first. The high-byte frame follows the low-byte
// frame with no idle gap.
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   fifo_empty - FIFO empty flag
//   fifo_dout  - FIFO read data, valid while fifo_pop is high
//   fifo_pop   - single-cycle pop strobe, high only in the POP state
//   tx         - UART serial line, idles high
//   busy       - high while a word is being fetched or transmitted
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [2:0]            idx, idx_nxt;
  logic                  hi, hi_nxt;
  logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
  logic                  bit_end;

  assign bit_end = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      hi    <= 1'b0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      hi    <= hi_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    hi_nxt    = hi;
    sreg_nxt  = sreg;
    tx        = 1'b1;
    busy      = 1'b1;
    fifo_pop  = 1'b0;

    case (state)
      IDLE: begin
        busy    = 1'b0;
        cnt_nxt = '0;
        if (!fifo_empty) state_nxt = POP;
      end

      POP: begin
        fifo_pop  = 1'b1;
        sreg_nxt  = fifo_dout;
        hi_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = START;
      end

      START: begin
        tx      = 1'b0;
        cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) begin
          idx_nxt   = '0;
          state_nxt = DATA;
        end
      end

      DATA: begin
        // The word shifts right one bit per data bit, so after the eight
        // low-byte bits the high byte already sits in sreg[7:0].
        tx      = sreg[0];
        cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) begin
          sreg_nxt = {1'b0, sreg[DATA_WIDTH-1:1]};
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      STOP: begin
        cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
        if (bit_end) begin
          if (!hi) begin
            hi_nxt    = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
